data_ram: RTL and testbench

//  Word-addressed single-port data memory for the RISC-V-32 core (data-memory stage).

---
 rtl/data_ram.sv | 47 ++++
 tb/tb_data_ram.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Word-addressed single-port data memory for the RISC-V-32 data-memory stage.
// Synchronous write with a synchronous clear-all reset; asynchronous (combinational) read.
module data_ram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 64,
  parameter int IDX_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  writeEnable,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData
);

  // Interface contract: no valid/ready handshake. The port is always ready;
  // writeEnable qualifies a write at the next rising edge, and readData is
  // valid combinationally for whatever address is presented.

  logic [DATA_WIDTH-1:0] memory [0:DEPTH-1];
  logic [IDX_BITS-1:0]   w_idx;

  // Upper address bits alias onto the low index; they are intentionally dropped.
  assign w_idx = address[IDX_BITS-1:0];

  generate
    if (ADDR_WIDTH > IDX_BITS) begin : g_addr_hi
      logic w_unused_addr_hi;
      assign w_unused_addr_hi = ^address[ADDR_WIDTH-1:IDX_BITS];
    end
  endgenerate

  // Reset outranks writeEnable: a reset cycle clears every word and writes nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        memory[i] <= '0;
      end
    end else if (writeEnable) begin
      memory[w_idx] <= writeData;
    end
  end

  assign readData = memory[w_idx];

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram: reset clear, write/read sweeps,
// write-disable, address aliasing, reset priority and read-during-write.
module tb_data_ram;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int DEPTH = 64;

  logic          clk;
  logic          reset;
  logic          writeEnable;
  logic [AW-1:0] address;
  logic [DW-1:0] writeData;
  logic [DW-1:0] readData;

  int n_cmp = 0;
  int n_err = 0;

  data_ram #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(32),
    .DEPTH(64),
    .IDX_BITS(6)
  ) dut (
    .clk(clk),
    .reset(reset),
    .writeEnable(writeEnable),
    .address(address),
    .writeData(writeData),
    .readData(readData)
  );

  // Clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  // Pattern word for index i: {i, ~i, 16'hC0DE}; index 5 carries DEADBEEF.
  function automatic logic [DW-1:0] pattern(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 5) return 32'hDEADBEEF;
    return {b, ~b, 16'hC0DE};
  endfunction

  // Driver tasks
  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge clk);
    writeEnable = 1'b1;
    address     = a;
    writeData   = d;
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    writeEnable = 1'b0;
    writeData   = '0;
    address     = '0;
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i);
      #1;
      n_cmp++;
      if (readData !== 32'h0) begin
        n_err++;
        $display("FAIL reset_clear addr=%0d got=%h required=%h", i, readData, 32'h0);
      end
    end
  endtask

  task automatic test_write_sweep();
    for (int i = 0; i < DEPTH; i++) begin
      do_write(AW'(i), pattern(i));
      n_cmp++;
      if (dut.memory[i] !== pattern(i)) begin
        n_err++;
        $display("FAIL write_sweep_mem idx=%0d got=%h required=%h", i, dut.memory[i], pattern(i));
      end
      n_cmp++;
      if (readData !== pattern(i)) begin
        n_err++;
        $display("FAIL write_sweep_rd idx=%0d got=%h required=%h", i, readData, pattern(i));
      end
    end
    n_cmp++;
    if (dut.memory[5] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL write_addr5 got=%h required=%h", dut.memory[5], 32'hDEADBEEF);
    end
  endtask

  task automatic test_read_back();
    @(negedge clk);
    writeEnable = 1'b0;
    writeData   = 32'hFFFF0000;
    for (int i = 0; i < DEPTH; i++) begin
      address = AW'(i);
      #1;
      n_cmp++;
      if (readData !== pattern(i)) begin
        n_err++;
        $display("FAIL read_back addr=%0d got=%h required=%h", i, readData, pattern(i));
      end
      @(posedge clk);
      #1;
    end
    for (int i = 0; i < DEPTH; i++) begin
      n_cmp++;
      if (dut.memory[i] !== pattern(i)) begin
        n_err++;
        $display("FAIL read_no_side_effect idx=%0d got=%h required=%h", i, dut.memory[i], pattern(i));
      end
    end
  endtask

  task automatic test_write_disable();
    @(negedge clk);
    writeEnable = 1'b0;
    address     = 32'd3;
    writeData   = 32'h12345678;
    @(posedge clk);
    #1;
    n_cmp++;
    if (dut.memory[3] !== 32'h03FCC0DE) begin
      n_err++;
      $display("FAIL write_disable_mem got=%h required=%h", dut.memory[3], 32'h03FCC0DE);
    end
    n_cmp++;
    if (readData !== 32'h03FCC0DE) begin
      n_err++;
      $display("FAIL write_disable_rd got=%h required=%h", readData, 32'h03FCC0DE);
    end
  endtask

  task automatic test_wrap_priority();
    do_write(32'd66, 32'hA5A5A5A5);
    n_cmp++;
    if (dut.memory[2] !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL wrap_mem2 got=%h required=%h", dut.memory[2], 32'hA5A5A5A5);
    end
    address = 32'd2;
    #1;
    n_cmp++;
    if (readData !== 32'hA5A5A5A5) begin
      n_err++;
      $display("FAIL wrap_rd2 got=%h required=%h", readData, 32'hA5A5A5A5);
    end
    address = 32'h8000_0041;
    #1;
    n_cmp++;
    if (readData !== 32'h01FEC0DE) begin
      n_err++;
      $display("FAIL wrap_rd_hi got=%h required=%h", readData, 32'h01FEC0DE);
    end
    // Reset with a simultaneous write request: the write must not land.
    @(negedge clk);
    reset       = 1'b1;
    writeEnable = 1'b1;
    address     = 32'd7;
    writeData   = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    reset       = 1'b0;
    writeEnable = 1'b0;
    n_cmp++;
    if (dut.memory[7] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_priority_mem7 got=%h required=%h", dut.memory[7], 32'h0);
    end
    n_cmp++;
    if (readData !== 32'h0) begin
      n_err++;
      $display("FAIL reset_priority_rd7 got=%h required=%h", readData, 32'h0);
    end
    n_cmp++;
    if (dut.memory[2] !== 32'h0) begin
      n_err++;
      $display("FAIL reset_clears_mem2 got=%h required=%h", dut.memory[2], 32'h0);
    end
  endtask

  task automatic test_read_during_write();
    do_write(32'd10, 32'h1);
    @(negedge clk);
    writeEnable = 1'b1;
    address     = 32'd10;
    writeData   = 32'h2;
    #1;
    n_cmp++;
    if (readData !== 32'h1) begin
      n_err++;
      $display("FAIL rdw_before_edge got=%h required=%h", readData, 32'h1);
    end
    @(posedge clk);
    #1;
    writeEnable = 1'b0;
    n_cmp++;
    if (readData !== 32'h2) begin
      n_err++;
      $display("FAIL rdw_after_edge got=%h required=%h", readData, 32'h2);
    end
  endtask

  task automatic test_back_to_back();
    do_write(32'd20, 32'h0000_1111);
    do_write(32'd21, 32'h0000_2222);
    do_write(32'd84, 32'h0000_3333);
    n_cmp++;
    if (dut.memory[20] !== 32'h0000_3333) begin
      n_err++;
      $display("FAIL b2b_alias20 got=%h required=%h", dut.memory[20], 32'h0000_3333);
    end
    n_cmp++;
    if (dut.memory[21] !== 32'h0000_2222) begin
      n_err++;
      $display("FAIL b2b_mem21 got=%h required=%h", dut.memory[21], 32'h0000_2222);
    end
    n_cmp++;
    if (dut.memory[22] !== 32'h0) begin
      n_err++;
      $display("FAIL b2b_neighbor22 got=%h required=%h", dut.memory[22], 32'h0);
    end
    address = 32'd10;
    #1;
    n_cmp++;
    if (readData !== 32'h2) begin
      n_err++;
      $display("FAIL b2b_keep10 got=%h required=%h", readData, 32'h2);
    end
  endtask

  initial begin
    reset       = 1'b0;
    writeEnable = 1'b0;
    address     = '0;
    writeData   = '0;
    repeat (2) @(posedge clk);
    test_reset();
    test_write_sweep();
    test_read_back();
    test_write_disable();
    test_wrap_priority();
    test_read_during_write();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
